// File: rtl/add_pipe_pkg.sv
// add_pipe_pkg: shared constants for the segmented pipelined adder.
//   WIDTH_DEF / SEG_DEF : default operand width and per-stage segment width
//   op_e                : encoding of the sub input (ADD = 0, SUB = 1)
package add_pipe_pkg;

   localparam int WIDTH_DEF = 32;
   localparam int SEG_DEF   = 8;

   typedef enum logic {
      ADD = 1'b0,
      SUB = 1'b1
   } op_e;

endpackage

// File: rtl/add_pipe_seg.sv
// add_seg: one SEG-bit slice of the pipelined adder together with its stage
// register. The slice result only moves when en is high; rst clears it.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   en             : stage advance enable
//   a_i, b_i, cin  : segment operands (b_i already conditionally inverted) and carry-in
//   sum_q          : registered segment sum
//   cout_q         : registered carry out of the segment MSB
//   cmsb_q         : registered carry into the segment MSB (used for overflow)
module add_seg
   import add_pipe_pkg::*;
#(
   parameter int SEG = SEG_DEF
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           en,
   input  logic [SEG-1:0] a_i,
   input  logic [SEG-1:0] b_i,
   input  logic           cin,
   output logic [SEG-1:0] sum_q,
   output logic           cout_q,
   output logic           cmsb_q
);

   logic [SEG-1:0] sum_d;
   logic           cout_d;
   logic           cmsb_d;

   always_comb begin
      {cout_d, sum_d} = {1'b0, a_i} + {1'b0, b_i} + {{SEG{1'b0}}, cin};
      // sum bit = a ^ b ^ carry_in, so the carry into the MSB falls out directly
      cmsb_d = a_i[SEG-1] ^ b_i[SEG-1] ^ sum_d[SEG-1];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sum_q  <= '0;
         cout_q <= 1'b0;
         cmsb_q <= 1'b0;
      end else if (en) begin
         sum_q  <= sum_d;
         cout_q <= cout_d;
         cmsb_q <= cmsb_d;
      end
   end

endmodule

// File: rtl/add_pipe.sv
// add_pipe: WIDTH-bit add/subtract split into NSEG = WIDTH/SEG pipeline stages.
// Stage k adds segment k using the carry registered by stage k-1; the upper
// operand segments ride along in delay registers and the finished lower result
// segments are carried forward until the last stage. The whole pipe moves as
// one (adv), so a stalled output freezes every stage and bubbles are preserved.
// WIDTH must be an integer multiple of SEG.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   a, b, sub           : operands (two's complement) and operation (0 add, 1 subtract)
//   in_valid, in_ready  : input handshake; in_ready = adv
//   r, carry, ovf       : result, raw carry out of MSB, signed overflow
//   out_valid, out_ready: output handshake
module add_pipe
   import add_pipe_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int SEG   = SEG_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] r,
   output logic             carry,
   output logic             ovf,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam int NSEG = WIDTH / SEG;

   logic             adv;

   logic             v_d   [NSEG];
   logic             v_q   [NSEG];
   logic [WIDTH-1:0] a_d   [NSEG];
   logic [WIDTH-1:0] a_q   [NSEG];
   logic [WIDTH-1:0] b_d   [NSEG];
   logic [WIDTH-1:0] b_q   [NSEG];
   logic [WIDTH-1:0] res_d [NSEG];
   logic [WIDTH-1:0] res_q [NSEG];

   logic [SEG-1:0]   seg_a   [NSEG];
   logic [SEG-1:0]   seg_b   [NSEG];
   logic             seg_cin [NSEG];
   logic [SEG-1:0]   sum_q   [NSEG];
   logic             cout_q  [NSEG];
   logic             cmsb_q  [NSEG];

   always_comb begin
      adv       = !v_q[NSEG-1] || out_ready;
      in_ready  = adv;
      out_valid = v_q[NSEG-1];
   end

   always_comb begin
      // stage 0 takes the ports; sub only matters here (inversion and carry-in)
      v_d[0]     = in_valid;
      a_d[0]     = a;
      b_d[0]     = (sub == SUB) ? ~b : b;
      res_d[0]   = '0;
      seg_a[0]   = a[SEG-1:0];
      seg_b[0]   = b_d[0][SEG-1:0];
      seg_cin[0] = sub;
      for (int k = 1; k < NSEG; k++) begin
         v_d[k]   = v_q[k-1];
         a_d[k]   = a_q[k-1];
         b_d[k]   = b_q[k-1];
         // fold the segment finished by the previous stage into the result word
         res_d[k] = res_q[k-1];
         res_d[k][(k-1)*SEG +: SEG] = sum_q[k-1];
         seg_a[k]   = a_q[k-1][k*SEG +: SEG];
         seg_b[k]   = b_q[k-1][k*SEG +: SEG];
         seg_cin[k] = cout_q[k-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < NSEG; k++) begin
            v_q[k]   <= 1'b0;
            a_q[k]   <= '0;
            b_q[k]   <= '0;
            res_q[k] <= '0;
         end
      end else if (adv) begin
         for (int k = 0; k < NSEG; k++) begin
            v_q[k]   <= v_d[k];
            a_q[k]   <= a_d[k];
            b_q[k]   <= b_d[k];
            res_q[k] <= res_d[k];
         end
      end
   end

   for (genvar k = 0; k < NSEG; k++) begin : g_seg
      add_seg #(
         .SEG (SEG)
      ) u_seg (
         .clk    (clk),
         .rst    (rst),
         .en     (adv),
         .a_i    (seg_a[k]),
         .b_i    (seg_b[k]),
         .cin    (seg_cin[k]),
         .sum_q  (sum_q[k]),
         .cout_q (cout_q[k]),
         .cmsb_q (cmsb_q[k])
      );
   end

   always_comb begin
      r = res_q[NSEG-1];
      r[(NSEG-1)*SEG +: SEG] = sum_q[NSEG-1];
      carry = cout_q[NSEG-1];
      ovf   = cmsb_q[NSEG-1] ^ cout_q[NSEG-1];
   end

endmodule

// File: tb/tb_add_pipe.sv
// tb_add_pipe: scoreboard bench for add_pipe. Directed vectors on a 32/8
// instance, plus random streams on 16/16 and 64/16 instances checked against
// a behavioural reference.
module tb_add_pipe;
   import add_pipe_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, rst_s;

   logic [31:0] a, b, r;
   logic        sub, in_valid, in_ready, carry, ovf, out_valid, out_ready;

   logic [15:0] a16, b16, r16;
   logic        sub16, iv16, ir16, c16, o16, ov16;
   logic        ordy16 = 1'b1;

   logic [63:0] a64, b64, r64;
   logic        sub64, iv64, ir64, c64, o64, ov64;
   logic        ordy64 = 1'b1;

   add_pipe #(.WIDTH(32), .SEG(8)) u_dut (
      .clk(clk), .rst(rst), .a(a), .b(b), .sub(sub), .in_valid(in_valid),
      .in_ready(in_ready), .r(r), .carry(carry), .ovf(ovf),
      .out_valid(out_valid), .out_ready(out_ready));

   add_pipe #(.WIDTH(16), .SEG(16)) u_d16 (
      .clk(clk), .rst(rst_s), .a(a16), .b(b16), .sub(sub16), .in_valid(iv16),
      .in_ready(ir16), .r(r16), .carry(c16), .ovf(o16),
      .out_valid(ov16), .out_ready(ordy16));

   add_pipe #(.WIDTH(64), .SEG(16)) u_d64 (
      .clk(clk), .rst(rst_s), .a(a64), .b(b64), .sub(sub64), .in_valid(iv64),
      .in_ready(ir64), .r(r64), .carry(c64), .ovf(o64),
      .out_valid(ov64), .out_ready(ordy64));

   typedef struct {
      logic [63:0] r;
      logic        c;
      logic        o;
      int          lat;
      int          acc;
   } exp_t;

   exp_t q32[$];
   exp_t q16[$];
   exp_t q64[$];
   exp_t e32, e16, e64;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic exp_t ref_add(input int w, input logic [63:0] x, input logic [63:0] y,
                                    input logic s, input int lat, input int acc);
      logic [63:0] mask, xx, yy, rr;
      logic [64:0] sum;
      exp_t        e;
      mask  = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
      xx    = x & mask;
      yy    = (s ? ~y : y) & mask;
      sum   = {1'b0, xx} + {1'b0, yy} + {64'd0, s};
      rr    = sum[63:0] & mask;
      e.r   = rr;
      e.c   = sum[w];
      e.o   = (xx[w-1] == yy[w-1]) && (rr[w-1] != xx[w-1]);
      e.lat = lat;
      e.acc = acc;
      return e;
   endfunction

   // monitors: pop and compare whenever a result is handed over
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (q32.size() == 0) chk("unexpected32", q32.size(), 1);
         else begin
            e32 = q32.pop_front();
            chk("r32", {32'b0, r}, e32.r);
            chk("carry32", carry, e32.c);
            chk("ovf32", ovf, e32.o);
            if (e32.lat >= 0) chk("lat32", cyc - e32.acc, e32.lat);
         end
      end
   end

   always @(negedge clk) begin
      if (!rst_s && ov16 && ordy16) begin
         if (q16.size() == 0) chk("unexpected16", q16.size(), 1);
         else begin
            e16 = q16.pop_front();
            chk("r16", {48'b0, r16}, e16.r);
            chk("carry16", c16, e16.c);
            chk("ovf16", o16, e16.o);
            chk("lat16", cyc - e16.acc, e16.lat);
         end
      end
   end

   always @(negedge clk) begin
      if (!rst_s && ov64 && ordy64) begin
         if (q64.size() == 0) chk("unexpected64", q64.size(), 1);
         else begin
            e64 = q64.pop_front();
            chk("r64", r64, e64.r);
            chk("carry64", c64, e64.c);
            chk("ovf64", o64, e64.o);
            chk("lat64", cyc - e64.acc, e64.lat);
         end
      end
   end

   // drive one operation (called at posedge+1), push its expectation on acceptance
   task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic isub,
                        input logic [31:0] er, input logic ec, input logic eo, input int elat);
      bit done = 1'b0;
      a = ia; b = ib; sub = isub; in_valid = 1'b1;
      for (int t = 0; t < 40 && !done; t++) begin
         @(negedge clk);
         if (in_ready) begin
            q32.push_back('{r: {32'b0, er}, c: ec, o: eo, lat: elat, acc: cyc});
            done = 1'b1;
         end
         @(posedge clk); #1;
      end
      chk("accept", {63'b0, done}, 64'd1);
   endtask

   task automatic drain32();
      for (int i = 0; i < 40 && q32.size() != 0; i++) @(negedge clk);
      chk("drain32", q32.size(), 0);
      @(posedge clk); #1;
   endtask

   logic [31:0] bb_a [8] = '{32'h00FF_FFFF, 32'h0000_00FF, 32'h0000_FFFF, 32'hFFFF_FFFF,
                             32'hFFFF_FFFF, 32'h1234_5678, 32'h8000_0000, 32'h7F7F_7F7F};
   logic [31:0] bb_b [8] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h0000_0001,
                             32'hFFFF_FFFF, 32'h9ABC_DEF0, 32'h8000_0000, 32'h0101_0101};
   logic [31:0] bb_r [8] = '{32'h0100_0000, 32'h0000_0100, 32'h0001_0000, 32'h0000_0000,
                             32'hFFFF_FFFE, 32'hACF1_3568, 32'h0000_0000, 32'h8080_8080};
   logic [7:0]  bb_c = 8'b0101_1000;   // bit i = carry of vector i
   logic [7:0]  bb_o = 8'b1100_0000;   // bit i = ovf of vector i

   logic [31:0] bp_a [4] = '{32'h1111_1111, 32'h4000_0000, 32'h0000_0005, 32'hFFFF_FFF0};
   logic [31:0] bp_b [4] = '{32'h2222_2222, 32'h4000_0000, 32'h0000_0003, 32'h0000_0010};
   logic [3:0]  bp_s = 4'b0100;
   logic [31:0] bp_r [4] = '{32'h3333_3333, 32'h8000_0000, 32'h0000_0002, 32'h0000_0000};
   logic [3:0]  bp_c = 4'b1100;
   logic [3:0]  bp_o = 4'b0010;

   task automatic main_seq();
      @(posedge clk); #1;
      // overflow and subtraction corners
      issue(32'h7FFF_FFFF, 32'h0000_0001, ADD, 32'h8000_0000, 1'b0, 1'b1, 4);
      in_valid = 1'b0;
      drain32();
      issue(32'h0000_0000, 32'h0000_0001, SUB, 32'hFFFF_FFFF, 1'b0, 1'b0, 4);
      issue(32'h8000_0000, 32'h0000_0001, SUB, 32'h7FFF_FFFF, 1'b1, 1'b1, 4);
      in_valid = 1'b0;
      drain32();

      // back-to-back adds with carries crossing segment boundaries
      for (int i = 0; i < 8; i++)
         issue(bb_a[i], bb_b[i], ADD, bb_r[i], bb_c[i], bb_o[i], 4);
      in_valid = 1'b0;
      drain32();

      // backpressure: fill the pipe with out_ready low, hold, release
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++)
         issue(bp_a[i], bp_b[i], bp_s[i], bp_r[i], bp_c[i], bp_o[i], -1);
      a = 32'h0000_000A; b = 32'h0000_000A; sub = SUB; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_in_ready", in_ready, 0);
         chk("bp_out_valid", out_valid, 1);
         chk("bp_r_hold", r, 32'h3333_3333);
         chk("bp_c_hold", carry, 0);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      issue(32'h0000_000A, 32'h0000_000A, SUB, 32'h0000_0000, 1'b1, 1'b0, -1);
      in_valid = 1'b0;
      drain32();

      // reset with three operations in flight
      issue(32'd1, 32'd1, ADD, 32'd2, 1'b0, 1'b0, 4);
      issue(32'd2, 32'd2, ADD, 32'd4, 1'b0, 1'b0, 4);
      issue(32'd3, 32'd3, ADD, 32'd6, 1'b0, 1'b0, 4);
      rst = 1'b1;
      a = 32'hDEAD_BEEF; b = 32'h1; sub = ADD; in_valid = 1'b1;
      q32.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_r", r, 0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("no_stale", out_valid, 0);
      end
      @(posedge clk); #1;
      issue(32'd5, 32'd7, ADD, 32'd12, 1'b0, 1'b0, 4);
      in_valid = 1'b0;
      drain32();
   endtask

   task automatic sweep_seq();
      @(posedge clk); #1;
      for (int i = 0; i < 24; i++) begin
         a16 = 16'($urandom); b16 = 16'($urandom); sub16 = 1'($urandom);
         a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom}; sub64 = 1'($urandom);
         if (i == 0) begin a16 = 16'h7FFF; b16 = 16'h0001; sub16 = 1'b0; end
         if (i == 1) begin a64 = 64'h8000_0000_0000_0000; b64 = 64'd1; sub64 = 1'b1; end
         iv16 = 1'b1; iv64 = 1'b1;
         @(negedge clk);
         if (ir16) q16.push_back(ref_add(16, {48'b0, a16}, {48'b0, b16}, sub16, 1, cyc));
         if (ir64) q64.push_back(ref_add(64, a64, b64, sub64, 4, cyc));
         @(posedge clk); #1;
      end
      iv16 = 1'b0; iv64 = 1'b0;
      for (int i = 0; i < 40 && (q16.size() != 0 || q64.size() != 0); i++) @(negedge clk);
      chk("drain16", q16.size(), 0);
      chk("drain64", q64.size(), 0);
   endtask

   initial begin
      rst = 1'b1; rst_s = 1'b1;
      a = '0; b = '0; sub = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      a16 = '0; b16 = '0; sub16 = 1'b0; iv16 = 1'b0;
      a64 = '0; b64 = '0; sub64 = 1'b0; iv64 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0; rst_s = 1'b0;
      @(negedge clk);
      chk("init_out_valid", out_valid, 0);
      chk("init_in_ready", in_ready, 1);
      chk("init_r", r, 0);
      chk("init_carry", carry, 0);
      chk("init_ovf", ovf, 0);
      fork
         main_seq();
         sweep_seq();
      join
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
